// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared state encoding and default widths for the regfile write arbiter
package regfile_pkg;

    localparam int DEFAULT_DATAPATH_WIDTH     = 64;
    localparam int DEFAULT_REGFILE_ADDR_WIDTH = 5;
    localparam int DEFAULT_NUM_REQ            = 4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } wr_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin selector: first asserted request at or after ptr, wrapping
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic found;
    int   idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found          = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - initialises a register file, then round-robin arbitrates write requesters
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int                        DATAPATH_WIDTH     = DEFAULT_DATAPATH_WIDTH,
    parameter int                        REGFILE_ADDR_WIDTH = DEFAULT_REGFILE_ADDR_WIDTH,
    parameter int                        NUM_REQ            = DEFAULT_NUM_REQ,
    parameter logic [DATAPATH_WIDTH-1:0] INIT_VALUE         = '0,
    parameter int                        ZERO_R0            = 1,
    localparam int                       IW                 = $clog2(NUM_REQ)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_REQ-1:0]                     req_valid,
    input  logic [NUM_REQ*REGFILE_ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATAPATH_WIDTH-1:0]      req_data,
    output logic [NUM_REQ-1:0]                     req_ready,
    output logic [REGFILE_ADDR_WIDTH-1:0]          wr_addr_out,
    output logic [DATAPATH_WIDTH-1:0]              wr_data_out,
    output logic                                   wena_out,
    output logic [IW-1:0]                          grant_id,
    output logic                                   init_done
);

    localparam logic [REGFILE_ADDR_WIDTH-1:0] LAST_ADDR = '1;

    wr_state_t                     state_q, state_d;
    logic [REGFILE_ADDR_WIDTH-1:0] init_cnt;
    logic [IW-1:0]                 ptr;
    logic [NUM_REQ-1:0]            grant;
    logic [IW-1:0]                 grant_idx;
    logic                          transfer;
    logic [REGFILE_ADDR_WIDTH-1:0] sel_addr;
    logic [DATAPATH_WIDTH-1:0]     sel_data;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Handshake outputs are gated by reset so they are quiet from the first reset cycle.
    assign req_ready = (state_q == ST_RUN && !reset) ? grant : '0;
    assign init_done = (state_q == ST_RUN) && !reset;
    assign transfer  = |req_ready;
    assign sel_addr  = req_addr[grant_idx*REGFILE_ADDR_WIDTH +: REGFILE_ADDR_WIDTH];
    assign sel_data  = req_data[grant_idx*DATAPATH_WIDTH +: DATAPATH_WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && init_cnt == LAST_ADDR) begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            init_cnt    <= '0;
            ptr         <= '0;
            wena_out    <= 1'b0;
            wr_addr_out <= '0;
            wr_data_out <= '0;
            grant_id    <= '0;
        end else if (state_q == ST_INIT) begin
            init_cnt    <= init_cnt + 1'b1;
            wena_out    <= 1'b1;
            wr_addr_out <= init_cnt;
            wr_data_out <= INIT_VALUE;
            grant_id    <= '0;
        end else if (transfer) begin
            // Address 0 is hardwired when ZERO_R0 is set: accept the write but suppress the enable.
            wena_out    <= !((ZERO_R0 != 0) && (sel_addr == '0));
            wr_addr_out <= sel_addr;
            wr_data_out <= sel_data;
            grant_id    <= grant_idx;
            ptr         <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end else begin
            wena_out    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - directed self-checking bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NR = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [NR-1:0]  req_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]  req_ready;
    logic [AW-1:0]  wr_addr_out;
    logic [DW-1:0]  wr_data_out;
    logic           wena_out;
    logic [1:0]     grant_id;
    logic           init_done;

    int checks   = 0;
    int failures = 0;

    regfile_wr_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .wr_addr_out (wr_addr_out),
        .wr_data_out (wr_data_out),
        .wena_out    (wena_out),
        .grant_id    (grant_id),
        .init_done   (init_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic check_write(input string tag, input int a, input logic [63:0] d, input int g);
        chk({tag, "_wena"}, 64'(wena_out), 64'd1);
        chk({tag, "_addr"}, 64'(wr_addr_out), 64'(a));
        chk({tag, "_data"}, wr_data_out, d);
        chk({tag, "_gid"}, 64'(grant_id), 64'(g));
    endtask

    initial begin
        int g;
        reset     = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        tick();
        tick();
        chk("rst_wena", 64'(wena_out), 64'd0);
        chk("rst_addr", 64'(wr_addr_out), 64'd0);
        chk("rst_data", wr_data_out, 64'd0);
        chk("rst_gid", 64'(grant_id), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);

        // Init sweep; requesters pester the block mid-sweep and must be refused.
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            chk("init_wena", 64'(wena_out), 64'd1);
            chk("init_addr", 64'(wr_addr_out), 64'(i));
            chk("init_data", wr_data_out, 64'd0);
            chk("init_done_flag", 64'(init_done), (i == 31) ? 64'd1 : 64'd0);
            if (i == 5) begin
                for (int r = 0; r < NR; r++) set_req(r, AW'(r + 3), DW'(r));
                req_valid = 4'hF;
                #1;
                chk("init_ready_zero", 64'(req_ready), 64'd0);
            end
            if (i == 20) req_valid = '0;
        end

        // All four requesters: grants rotate 0,1,2,3,0.
        for (int r = 0; r < NR; r++) set_req(r, AW'(8 + r), DW'(64'h100 + r));
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            g = k % 4;
            #1;
            chk("rr_ready", 64'(req_ready), 64'(1 << g));
            tick();
            check_write("rr", 8 + g, 64'h100 + 64'(g), g);
        end
        req_valid = '0;
        tick();
        chk("idle_wena", 64'(wena_out), 64'd0);
        chk("idle_addr_hold", 64'(wr_addr_out), 64'd8);
        chk("idle_data_hold", wr_data_out, 64'h100);

        // Lone requester 2 with ptr at 1.
        set_req(2, 5'd7, 64'hDEAD);
        req_valid = 4'b0100;
        #1;
        chk("r2_ready", 64'(req_ready), 64'b0100);
        tick();
        check_write("r2", 7, 64'hDEAD, 2);
        req_valid = '0;

        // Requester 1 writes r0: handshake completes, no enable, ptr moves to 2.
        set_req(1, 5'd0, 64'h55);
        req_valid = 4'b0010;
        #1;
        chk("r0_ready", 64'(req_ready), 64'b0010);
        tick();
        chk("r0_wena", 64'(wena_out), 64'd0);
        req_valid = 4'hF;
        #1;
        chk("ptr_after_r0", 64'(req_ready), 64'b0100);
        tick();
        check_write("after_r0", 7, 64'hDEAD, 2);
        req_valid = '0;
        tick();
        chk("idle2_wena", 64'(wena_out), 64'd0);

        // Reset in the middle of a fresh init sweep.
        reset = 1'b1;
        tick();
        chk("rst2_init_done", 64'(init_done), 64'd0);
        reset = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            tick();
            chk("sweep1_addr", 64'(wr_addr_out), 64'(i));
        end
        reset = 1'b1;
        tick();
        chk("midrst_wena", 64'(wena_out), 64'd0);
        chk("midrst_init_done", 64'(init_done), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            chk("sweep2_wena", 64'(wena_out), 64'd1);
            chk("sweep2_addr", 64'(wr_addr_out), 64'(i));
            chk("sweep2_done", 64'(init_done), (i == 31) ? 64'd1 : 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
